// File: rtl/multiexp_pkg.sv
// Shared definitions for the multiexp datapath and its feeders.
package multiexp_pkg;

   // Width of the per-word control field carried to the multiexp top (pass index).
   localparam int unsigned CTL_BITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      REPLAY
   } replay_state_t;

endpackage

// File: rtl/if_axi_stream.sv
// AXI-stream style bundle: val/rdy handshake with framing, error and control sideband.
interface if_axi_stream #(
   parameter int unsigned DAT_BITS = 8,
   parameter int unsigned CTL_BITS = 8
) ();
   logic                val;
   logic                rdy;
   logic                sop;
   logic                eop;
   logic                err;
   logic [CTL_BITS-1:0] ctl;
   logic [DAT_BITS-1:0] dat;

   modport src  (output val, sop, eop, err, ctl, dat, input rdy);
   modport sink (input val, sop, eop, err, ctl, dat, output rdy);
endinterface

// File: rtl/replay_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module replay_ram #(
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned DAT_BITS = 768
) (
   input  logic                     i_clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DAT_BITS-1:0]      wr_dat,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DAT_BITS-1:0]      rd_dat
);

   logic [DAT_BITS-1:0] mem [DEPTH];

   // Write port and registered read port; contents are never reset.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_addr] <= wr_dat;
      if (rd_en) rd_dat <= mem[rd_addr];
   end

endmodule

// File: rtl/multiexp_replay_buf.sv
// Stores one {point,scalar} list while forwarding it live (pass 0), then replays it
// from RAM for passes 1..KEY_BITS-1 so the host sends each list only once.
module multiexp_replay_buf
   import multiexp_pkg::*;
#(
   parameter int unsigned DAT_BITS = 768,
   parameter int unsigned KEY_BITS = 256,
   parameter int unsigned DEPTH    = 1024
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [$clog2(DEPTH):0] i_num_in,
   if_axi_stream.sink             i_pnt_scl_if,
   if_axi_stream.src              o_pnt_scl_if,
   output logic                   o_busy,
   output logic                   o_cfg_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NW = AW + 1;
   localparam int unsigned PW = $clog2(KEY_BITS) + 1;

   typedef struct packed {
      logic [DAT_BITS-1:0] dat;
      logic                sop;
      logic                eop;
      logic [CTL_BITS-1:0] ctl;
   } word_t;

   replay_state_t       state_q, state_d;
   logic [NW-1:0]       num_q, last_idx;
   logic [AW-1:0]       wr_cnt_q, rd_addr_q;
   logic [PW-1:0]       pass_q;
   logic                rd_done_q, inflight_q, cfg_err_q;
   logic                meta_sop_q, meta_eop_q;
   logic [CTL_BITS-1:0] meta_ctl_q;
   word_t               fifo_q [2];
   word_t               head;
   logic                wptr_q, rptr_q;
   logic [1:0]          cnt_q;
   logic [DAT_BITS-1:0] ram_rd_dat;
   logic                start, bad_num, wr_en, load_last, rd_en, rd_last, rd_final;
   logic                push, pop, done;

   replay_ram #(
      .DEPTH    (DEPTH),
      .DAT_BITS (DAT_BITS)
   ) u_ram (
      .i_clk   (i_clk),
      .wr_en   (wr_en),
      .wr_addr (wr_cnt_q),
      .wr_dat  (i_pnt_scl_if.dat),
      .rd_en   (rd_en),
      .rd_addr (rd_addr_q),
      .rd_dat  (ram_rd_dat)
   );

   // Control strobes shared by the FSM and the datapath.
   always_comb begin
      last_idx  = num_q - NW'(1);
      head      = fifo_q[rptr_q];
      bad_num   = (i_num_in == '0) || (i_num_in > NW'(DEPTH));
      start     = (state_q == IDLE) && i_pnt_scl_if.val && !cfg_err_q;
      wr_en     = (state_q == LOAD) && i_pnt_scl_if.val && o_pnt_scl_if.rdy;
      load_last = wr_en && ({1'b0, wr_cnt_q} == last_idx);
      pop       = (state_q == REPLAY) && (cnt_q != 2'd0) && o_pnt_scl_if.rdy;
      push      = inflight_q;
      // Counting this cycle's pop keeps one read per cycle in steady state.
      rd_en     = (state_q == REPLAY) && !rd_done_q &&
                  ((int'(cnt_q) + int'(inflight_q) - int'(pop)) < 2);
      rd_last   = ({1'b0, rd_addr_q} == last_idx);
      rd_final  = rd_last && (32'(pass_q) == KEY_BITS - 1);
      // With all reads issued and nothing in flight, a lone FIFO entry is the final word.
      done      = pop && rd_done_q && !inflight_q && (cnt_q == 2'd1);
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start && !bad_num) state_d = LOAD;
         LOAD:    if (load_last) state_d = (KEY_BITS == 1) ? IDLE : REPLAY;
         REPLAY:  if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: live pass-through in LOAD, FIFO head in REPLAY.
   always_comb begin
      i_pnt_scl_if.rdy = 1'b0;
      o_pnt_scl_if.val = 1'b0;
      o_pnt_scl_if.dat = head.dat;
      o_pnt_scl_if.sop = 1'b0;
      o_pnt_scl_if.eop = 1'b0;
      o_pnt_scl_if.err = 1'b0;
      o_pnt_scl_if.ctl = '0;
      unique case (state_q)
         LOAD: begin
            i_pnt_scl_if.rdy = o_pnt_scl_if.rdy;
            o_pnt_scl_if.val = i_pnt_scl_if.val;
            o_pnt_scl_if.dat = i_pnt_scl_if.dat;
            o_pnt_scl_if.sop = (wr_cnt_q == '0);
            o_pnt_scl_if.eop = ({1'b0, wr_cnt_q} == last_idx);
         end
         REPLAY: begin
            o_pnt_scl_if.val = (cnt_q != 2'd0);
            o_pnt_scl_if.sop = head.sop;
            o_pnt_scl_if.eop = head.eop;
            o_pnt_scl_if.ctl = head.ctl;
         end
         default: ;
      endcase
      // Reset aborts at once, even before the state register clears.
      if (i_rst) begin
         i_pnt_scl_if.rdy = 1'b0;
         o_pnt_scl_if.val = 1'b0;
         o_pnt_scl_if.sop = 1'b0;
         o_pnt_scl_if.eop = 1'b0;
         o_pnt_scl_if.ctl = '0;
      end
      o_busy    = (state_q != IDLE);
      o_cfg_err = cfg_err_q;
   end

   // Counters, pass tracking, read pipeline and FIFO pointers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cfg_err_q  <= 1'b0;
         num_q      <= '0;
         wr_cnt_q   <= '0;
         rd_addr_q  <= '0;
         pass_q     <= '0;
         rd_done_q  <= 1'b0;
         inflight_q <= 1'b0;
         meta_sop_q <= 1'b0;
         meta_eop_q <= 1'b0;
         meta_ctl_q <= '0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         cnt_q      <= 2'd0;
      end else begin
         inflight_q <= rd_en;
         if (start) begin
            if (bad_num) begin
               cfg_err_q <= 1'b1;
            end else begin
               num_q     <= i_num_in;
               wr_cnt_q  <= '0;
               rd_addr_q <= '0;
               pass_q    <= '0;
               rd_done_q <= 1'b0;
               wptr_q    <= 1'b0;
               rptr_q    <= 1'b0;
               cnt_q     <= 2'd0;
            end
         end
         if (wr_en)     wr_cnt_q <= wr_cnt_q + AW'(1);
         if (load_last) pass_q   <= PW'(1);
         if (rd_en) begin
            meta_sop_q <= (rd_addr_q == '0);
            meta_eop_q <= rd_last;
            meta_ctl_q <= CTL_BITS'(pass_q);
            if (rd_last) begin
               rd_addr_q <= '0;
               if (rd_final) rd_done_q <= 1'b1;
               else          pass_q    <= pass_q + PW'(1);
            end else begin
               rd_addr_q <= rd_addr_q + AW'(1);
            end
         end
         if (push) wptr_q <= ~wptr_q;
         if (pop)  rptr_q <= ~rptr_q;
         if (state_q == REPLAY) cnt_q <= cnt_q + 2'(push) - 2'(pop);
      end
   end

   // Skid FIFO storage: captures RAM read data with its framing.
   always_ff @(posedge i_clk) begin
      if (push) fifo_q[wptr_q] <= '{dat: ram_rd_dat, sop: meta_sop_q, eop: meta_eop_q,
                                    ctl: meta_ctl_q};
   end

endmodule

// File: tb/tb_multiexp_replay_buf.sv
// Scoreboard bench for multiexp_replay_buf: stimulus pushes expected words, a monitor
// pops and compares on every output transfer.
module tb_multiexp_replay_buf;

   localparam int unsigned DW = 16;
   localparam int unsigned KB = 4;
   localparam int unsigned DP = 8;
   localparam int unsigned NW = $clog2(DP) + 1;

   typedef struct {
      logic [DW-1:0] dat;
      logic          sop;
      logic          eop;
      logic [7:0]    ctl;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [NW-1:0] num_in;
   logic          busy, cfg_err;
   int            total, bad, cyc, n_ctl2;
   bit            rnd_rdy;
   exp_t          exp_q [$];
   int            xfer_cyc [$];
   logic [DW-1:0] words [DP];

   if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(8)) in_if ();
   if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(8)) out_if ();

   multiexp_replay_buf #(
      .DAT_BITS (DW),
      .KEY_BITS (KB),
      .DEPTH    (DP)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_num_in     (num_in),
      .i_pnt_scl_if (in_if),
      .o_pnt_scl_if (out_if),
      .o_busy       (busy),
      .o_cfg_err    (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Sink ready: always 1, or 50% random while rnd_rdy is set.
   initial begin
      out_if.rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1 out_if.rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compare each transfer with the scoreboard and check hold-while-stalled.
   initial begin
      exp_t          e;
      bit            stalled = 0;
      logic [25:0]   held = '0;
      logic [25:0]   cur;
      forever begin
         @(negedge clk);
         cur = {out_if.dat, out_if.sop, out_if.eop, out_if.ctl};
         if (rst) begin
            stalled = 0;
         end else begin
            if (out_if.val && stalled) chk("stall_hold", 64'(cur), 64'(held));
            if (out_if.val && out_if.rdy) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_word act=%0h exp=none", out_if.dat);
               end else begin
                  e = exp_q.pop_front();
                  chk("dat", 64'(out_if.dat), 64'(e.dat));
                  chk("sop", 64'(out_if.sop), 64'(e.sop));
                  chk("eop", 64'(out_if.eop), 64'(e.eop));
                  chk("ctl", 64'(out_if.ctl), 64'(e.ctl));
               end
               xfer_cyc.push_back(cyc);
               if (out_if.ctl == 8'd2) n_ctl2++;
            end
            stalled = out_if.val && !out_if.rdy;
            held    = cur;
         end
      end
   end

   task automatic push_exp(input int n);
      exp_t e;
      for (int p = 0; p < int'(KB); p++) begin
         for (int a = 0; a < n; a++) begin
            e.dat = words[a];
            e.sop = (a == 0);
            e.eop = (a == n - 1);
            e.ctl = 8'(p);
            exp_q.push_back(e);
         end
      end
   endtask

   // Starts and ends just after a rising edge.
   task automatic do_reset();
      rst = 1'b1;
      in_if.val = 1'b0;
      @(negedge clk);
      chk("rst_in_rdy", 64'(in_if.rdy), 0);
      chk("rst_out_val", 64'(out_if.val), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_cfg_err", 64'(cfg_err), 0);
      chk("rst_out_val2", 64'(out_if.val), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int n);
      int  idx = 0;
      int  tmo = 0;
      bit  acc;
      num_in    = NW'(n);
      in_if.dat = words[0];
      in_if.val = 1'b1;
      while (idx < n && tmo < 1000) begin
         @(negedge clk);
         acc = in_if.val && in_if.rdy;
         @(posedge clk);
         #1;
         tmo++;
         if (acc) begin
            idx++;
            if (idx < n) in_if.dat = words[idx];
         end
      end
      in_if.val = 1'b0;
      chk("send_accepted", 64'(idx), 64'(n));
   endtask

   task automatic wait_idle();
      int tmo = 0;
      do begin
         @(negedge clk);
         tmo++;
      end while ((busy || exp_q.size() != 0) && tmo < 3000);
      chk("end_busy", 64'(busy), 0);
      chk("end_drained", 64'(exp_q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic bad_cfg(input int n);
      num_in    = NW'(n);
      in_if.dat = 16'h1234;
      in_if.val = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("cfg_in_rdy", 64'(in_if.rdy), 0);
      end
      chk("cfg_err_set", 64'(cfg_err), 1);
      chk("cfg_busy", 64'(busy), 0);
      @(posedge clk);
      #1 in_if.val = 1'b0;
   endtask

   initial begin
      int tmo;
      total = 0; bad = 0; cyc = 0; n_ctl2 = 0; rnd_rdy = 0;
      rst = 1'b1; num_in = '0;
      in_if.val = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0;
      in_if.err = 1'b0; in_if.ctl = '0; in_if.dat = '0;
      @(posedge clk);
      #1 do_reset();

      // Four words, always ready: ABCD x4, contiguous replay.
      for (int i = 0; i < 4; i++) words[i] = DW'(16'hA + i);
      push_exp(4);
      xfer_cyc.delete();
      send(4);
      wait_idle();
      chk("t1_xfers", 64'(xfer_cyc.size()), 16);
      if (xfer_cyc.size() == 16) begin
         chk("t1_replay_latency", 64'(xfer_cyc[4] - xfer_cyc[3]), 3);
         chk("t1_replay_nogap", 64'(xfer_cyc[15] - xfer_cyc[4]), 11);
      end

      // Seven words under random backpressure.
      for (int i = 0; i < 7; i++) words[i] = DW'(16'h3100 + 16'h11 * i);
      rnd_rdy = 1;
      push_exp(7);
      xfer_cyc.delete();
      send(7);
      wait_idle();
      rnd_rdy = 0;
      chk("t2_xfers", 64'(xfer_cyc.size()), 28);

      // Single-word list: every word is both sop and eop.
      words[0] = 16'h0055;
      push_exp(1);
      send(1);
      wait_idle();

      // Full-depth list: address reaches DEPTH-1 and wraps.
      for (int i = 0; i < int'(DP); i++) words[i] = DW'(16'hC000 + 16'h101 * i);
      rnd_rdy = 1;
      push_exp(int'(DP));
      send(int'(DP));
      wait_idle();
      rnd_rdy = 0;

      // Illegal lengths latch the sticky error and refuse the list.
      do_reset();
      bad_cfg(0);
      do_reset();
      bad_cfg(int'(DP) + 1);
      do_reset();

      // Reset in the middle of pass 2, then a fresh two-word list.
      for (int i = 0; i < 3; i++) words[i] = DW'(16'h7700 + i);
      push_exp(3);
      n_ctl2 = 0;
      send(3);
      tmo = 0;
      while (n_ctl2 == 0 && tmo < 500) begin
         @(negedge clk);
         tmo++;
      end
      chk("t6_reached_pass2", 64'(n_ctl2 != 0), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("t6_rst_val", 64'(out_if.val), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_post_val", 64'(out_if.val), 0);
      chk("t6_post_busy", 64'(busy), 0);
      @(posedge clk);
      #1;
      words[0] = 16'h00E1;
      words[1] = 16'h00E2;
      push_exp(2);
      xfer_cyc.delete();
      send(2);
      wait_idle();
      chk("t6_xfers", 64'(xfer_cyc.size()), 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
